// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: ALU, branch flags/targets, HI/LO with multiplier
// and, when EX_DIVIDER_EN is defined, an iterative restoring divider that stalls the front end.
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] id_ex_reg_a_data,
    input  logic [31:0] id_ex_reg_b_data,
    input  logic [31:0] id_ex_imm,
    input  logic [4:0]  id_ex_shamt,
    input  logic [31:0] id_ex_pc_plus4,
    input  logic [25:0] id_ex_instr_index,
    input  logic [4:0]  id_ex_rd,
    input  logic [3:0]  id_ex_ctrl_alu_op,
    input  logic        id_ex_ctrl_alu_src,
    input  logic        id_ex_ctrl_shift_var,
    input  logic [2:0]  id_ex_ctrl_md_op,
    input  logic        id_ex_ctrl_branch,
    input  logic        id_ex_ctrl_jump,
    input  logic        id_ex_ctrl_jump_reg,
    input  logic        id_ex_ctrl_mem_to_reg,
    input  logic        id_ex_ctrl_mem_write,
    input  logic        id_ex_ctrl_reg_write,
    input  logic [2:0]  id_ex_ctrl_branch_type,
    input  logic [2:0]  id_ex_ctrl_load_type,
    input  logic [1:0]  id_ex_ctrl_store_type,
    output logic        ex_stall,
    output logic [31:0] ex_mem_alu_out,
    output logic        ex_mem_alu_beq_sig,
    output logic        ex_mem_alu_bne_sig,
    output logic        ex_mem_alu_bgez_sig,
    output logic        ex_mem_alu_bgtz_sig,
    output logic        ex_mem_alu_blez_sig,
    output logic        ex_mem_alu_bltz_sig,
    output logic [31:0] ex_mem_pc_branch,
    output logic [31:0] ex_mem_pc_jump,
    output logic [31:0] ex_mem_reg_b_data,
    output logic [4:0]  ex_mem_rd,
    output logic        ex_mem_ctrl_branch,
    output logic        ex_mem_ctrl_jump,
    output logic        ex_mem_ctrl_jump_reg,
    output logic        ex_mem_ctrl_mem_to_reg,
    output logic        ex_mem_ctrl_mem_write,
    output logic        ex_mem_ctrl_reg_write,
    output logic [2:0]  ex_mem_ctrl_branch_type,
    output logic [2:0]  ex_mem_ctrl_load_type,
    output logic [1:0]  ex_mem_ctrl_store_type
);
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;

    logic [31:0] reg_a, reg_b, op_b, alu_res, result;
    logic [4:0]  shift_amt;
    logic [5:0]  flags;
    logic [31:0] pc_branch, pc_jump;
    logic [63:0] mul_a, mul_b, product;
    logic        is_mult, bubble, div_write;
    logic [31:0] div_hi, div_lo;
    logic [13:0] ctrl_in;

    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] alu_out_q, alu_out_d, pc_branch_q, pc_branch_d, pc_jump_q, pc_jump_d;
    logic [31:0] reg_b_q, reg_b_d;
    logic [5:0]  flags_q, flags_d;
    logic [4:0]  rd_q, rd_d;
    logic [13:0] ctrl_q, ctrl_d;

    always_comb begin
        reg_a     = id_ex_reg_a_data;
        reg_b     = id_ex_reg_b_data;
        op_b      = id_ex_ctrl_alu_src ? id_ex_imm : reg_b;
        shift_amt = id_ex_ctrl_shift_var ? reg_a[4:0] : id_ex_shamt;
        case (id_ex_ctrl_alu_op)
            4'd0:    alu_res = reg_a + op_b;
            4'd1:    alu_res = reg_a - op_b;
            4'd2:    alu_res = reg_a & op_b;
            4'd3:    alu_res = reg_a | op_b;
            4'd4:    alu_res = reg_a ^ op_b;
            4'd5:    alu_res = ~(reg_a | op_b);
            4'd6:    alu_res = {31'd0, $signed(reg_a) < $signed(op_b)};
            4'd7:    alu_res = {31'd0, reg_a < op_b};
            4'd8:    alu_res = op_b << shift_amt;
            4'd9:    alu_res = op_b >> shift_amt;
            4'd10:   alu_res = $unsigned($signed(op_b) >>> shift_amt);
            4'd11:   alu_res = {id_ex_imm[15:0], 16'h0000};
            4'd12:   alu_res = id_ex_pc_plus4;
            default: alu_res = 32'd0;
        endcase
        case (id_ex_ctrl_md_op)
            MD_MFHI: result = hi_q;
            MD_MFLO: result = lo_q;
            default: result = alu_res;
        endcase
        // Branch flags always compare the register operands, never the immediate.
        flags = {reg_a == reg_b, reg_a != reg_b, !reg_a[31], !reg_a[31] && (reg_a != 32'd0),
                 reg_a[31] || (reg_a == 32'd0), reg_a[31]};
        pc_branch = id_ex_pc_plus4 + {id_ex_imm[29:0], 2'b00};
        pc_jump   = id_ex_ctrl_jump_reg ? reg_a
                                        : {id_ex_pc_plus4[31:28], id_ex_instr_index, 2'b00};
        is_mult = (id_ex_ctrl_md_op == MD_MULT) || (id_ex_ctrl_md_op == MD_MULTU);
        mul_a   = (id_ex_ctrl_md_op == MD_MULT) ? {{32{reg_a[31]}}, reg_a} : {32'd0, reg_a};
        mul_b   = (id_ex_ctrl_md_op == MD_MULT) ? {{32{reg_b[31]}}, reg_b} : {32'd0, reg_b};
        product = mul_a * mul_b;
        ctrl_in = {id_ex_ctrl_branch, id_ex_ctrl_jump, id_ex_ctrl_jump_reg, id_ex_ctrl_mem_to_reg,
                   id_ex_ctrl_mem_write, id_ex_ctrl_reg_write, id_ex_ctrl_branch_type,
                   id_ex_ctrl_load_type, id_ex_ctrl_store_type};
    end

`ifdef EX_DIVIDER_EN
    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
    localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

    div_state_e       div_state_q, div_state_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [31:0]      div_rem_q, div_rem_d, div_quo_q, div_quo_d;
    logic [31:0]      div_dvs_q, div_dvs_d, div_raw_q, div_raw_d;
    logic             div_qneg_q, div_qneg_d, div_rneg_q, div_rneg_d, div_zero_q, div_zero_d;
    logic             is_div, div_signed;
    logic [32:0]      rem_shift, rem_diff;

    always_comb begin
        is_div      = (id_ex_ctrl_md_op == MD_DIV) || (id_ex_ctrl_md_op == MD_DIVU);
        div_signed  = (id_ex_ctrl_md_op == MD_DIV);
        div_state_d = div_state_q;
        div_cnt_d   = div_cnt_q;
        div_rem_d   = div_rem_q;
        div_quo_d   = div_quo_q;
        div_dvs_d   = div_dvs_q;
        div_raw_d   = div_raw_q;
        div_qneg_d  = div_qneg_q;
        div_rneg_d  = div_rneg_q;
        div_zero_d  = div_zero_q;
        rem_shift   = {div_rem_q, div_quo_q[31]};
        rem_diff    = rem_shift - {1'b0, div_dvs_q};
        div_lo = div_zero_q ? 32'hFFFF_FFFF : (div_qneg_q ? -div_quo_q : div_quo_q);
        div_hi = div_zero_q ? div_raw_q : (div_rneg_q ? -div_rem_q : div_rem_q);
        case (div_state_q)
            DIV_IDLE: begin
                if (is_div && !flush) begin
                    div_state_d = DIV_BUSY;
                    div_cnt_d   = '0;
                    div_rem_d   = 32'd0;
                    div_quo_d   = (div_signed && reg_a[31]) ? -reg_a : reg_a;
                    div_dvs_d   = (div_signed && reg_b[31]) ? -reg_b : reg_b;
                    div_raw_d   = reg_a;
                    div_qneg_d  = div_signed && (reg_a[31] ^ reg_b[31]);
                    div_rneg_d  = div_signed && reg_a[31];
                    div_zero_d  = (reg_b == 32'd0);
                end
            end
            DIV_BUSY: begin
                if (flush) begin
                    div_state_d = DIV_IDLE;
                end else begin
                    // Restoring step: dividend bits shift into the remainder as quotient bits fill in.
                    if (!rem_diff[32]) begin
                        div_rem_d = rem_diff[31:0];
                        div_quo_d = {div_quo_q[30:0], 1'b1};
                    end else begin
                        div_rem_d = rem_shift[31:0];
                        div_quo_d = {div_quo_q[30:0], 1'b0};
                    end
                    div_cnt_d = div_cnt_q + CNT_W'(1);
                    if (div_cnt_q == CNT_W'(DIV_CYCLES - 1)) div_state_d = DIV_DONE;
                end
            end
            default: div_state_d = DIV_IDLE;
        endcase
    end

    assign div_write = (div_state_q == DIV_DONE);
    assign ex_stall  = rst_n && (((div_state_q == DIV_IDLE) && is_div && !flush) ||
                                 (div_state_q == DIV_BUSY));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_state_q <= DIV_IDLE;
            div_cnt_q   <= '0;
            div_rem_q   <= 32'd0;
            div_quo_q   <= 32'd0;
            div_dvs_q   <= 32'd0;
            div_raw_q   <= 32'd0;
            div_qneg_q  <= 1'b0;
            div_rneg_q  <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            div_state_q <= div_state_d;
            div_cnt_q   <= div_cnt_d;
            div_rem_q   <= div_rem_d;
            div_quo_q   <= div_quo_d;
            div_dvs_q   <= div_dvs_d;
            div_raw_q   <= div_raw_d;
            div_qneg_q  <= div_qneg_d;
            div_rneg_q  <= div_rneg_d;
            div_zero_q  <= div_zero_d;
        end
    end
`else
    assign div_write = 1'b0;
    assign div_hi    = 32'd0;
    assign div_lo    = 32'd0;
    assign ex_stall  = 1'b0;
`endif

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (is_mult && !flush && !ex_stall) {hi_d, lo_d} = product;
        // DONE writes even under flush: the divide has already left for MEM.
        if (div_write) {hi_d, lo_d} = {div_hi, div_lo};
        bubble      = flush || ex_stall;
        alu_out_d   = result;
        flags_d     = flags;
        pc_branch_d = pc_branch;
        pc_jump_d   = pc_jump;
        reg_b_d     = reg_b;
        rd_d        = id_ex_rd;
        ctrl_d      = bubble ? 14'd0 : ctrl_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            alu_out_q   <= 32'd0;
            flags_q     <= 6'd0;
            pc_branch_q <= 32'd0;
            pc_jump_q   <= 32'd0;
            reg_b_q     <= 32'd0;
            rd_q        <= 5'd0;
            ctrl_q      <= 14'd0;
        end else begin
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            alu_out_q   <= alu_out_d;
            flags_q     <= flags_d;
            pc_branch_q <= pc_branch_d;
            pc_jump_q   <= pc_jump_d;
            reg_b_q     <= reg_b_d;
            rd_q        <= rd_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign ex_mem_alu_out    = alu_out_q;
    assign ex_mem_pc_branch  = pc_branch_q;
    assign ex_mem_pc_jump    = pc_jump_q;
    assign ex_mem_reg_b_data = reg_b_q;
    assign ex_mem_rd         = rd_q;
    assign {ex_mem_alu_beq_sig, ex_mem_alu_bne_sig, ex_mem_alu_bgez_sig, ex_mem_alu_bgtz_sig,
            ex_mem_alu_blez_sig, ex_mem_alu_bltz_sig} = flags_q;
    assign {ex_mem_ctrl_branch, ex_mem_ctrl_jump, ex_mem_ctrl_jump_reg, ex_mem_ctrl_mem_to_reg,
            ex_mem_ctrl_mem_write, ex_mem_ctrl_reg_write, ex_mem_ctrl_branch_type,
            ex_mem_ctrl_load_type, ex_mem_ctrl_store_type} = ctrl_q;
endmodule
